interrupt_dispatcher: RTL

Hart-side counterpart of the platform interrupt controller. Drives the controller's CPU register interface as a bus initiator. On an external interrupt pulse it claims the highest-priority source, hands the source ID to the core, and waits for the handler to finish. It then writes the completion that re-arms the controller. It sits between the controller's interrupt output and bus port and the core's trap logic, and also programs the source-enable register after reset.

---
 rtl/interrupt_dispatcher_pkg.sv | 36 +++
 rtl/interrupt_dispatcher_if.sv | 14 +
 rtl/interrupt_dispatcher_bus_strobe_initiator.sv | 78 +++++++
 rtl/interrupt_dispatcher.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/interrupt_dispatcher_pkg.sv
// Shared constants, state encoding and bus payload type for the interrupt dispatcher.
package interrupt_dispatcher_pkg;

    localparam int unsigned ADDR_W         = 24;
    localparam int unsigned DATA_W         = 32;
    localparam int unsigned ID_W           = 3;
    localparam int unsigned NUM_SOURCES    = 4;
    localparam int unsigned CNT_W          = 8;
    localparam int unsigned TIMEOUT_CYCLES = 255;

    localparam logic [ADDR_W-1:0] PLIC_ENABLE_ADDR = 24'h002000;
    localparam logic [ADDR_W-1:0] PLIC_CLAIM_ADDR  = 24'h200004;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_CLAIM,
        ST_DELIVER,
        ST_WAIT_DONE,
        ST_COMPLETE
    } state_e;

    typedef struct packed {
        logic              rw;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } bus_req_t;

    // A claim word names a real source only if the upper bits are clear and the ID is 1..NUM_SOURCES.
    function automatic logic claim_id_valid(input logic [DATA_W-1:0] rdata);
        return (rdata[DATA_W-1:ID_W] == '0) &&
               (rdata[ID_W-1:0] != '0) &&
               (rdata[ID_W-1:0] <= ID_W'(NUM_SOURCES));
    endfunction

endpackage

// File: rtl/interrupt_dispatcher_if.sv
// Register-bus connection between the dispatcher (master) and the interrupt controller (slave).
interface interrupt_dispatcher_if;
    import interrupt_dispatcher_pkg::*;

    logic              o_request;
    logic              o_rw;
    logic [ADDR_W-1:0] o_address;
    logic [DATA_W-1:0] o_wdata;
    logic [DATA_W-1:0] i_rdata;
    logic              i_ready;

    modport master (output o_request, o_rw, o_address, o_wdata, input i_rdata, i_ready);
    modport slave  (input o_request, o_rw, o_address, o_wdata, output i_rdata, i_ready);
endinterface

// File: rtl/interrupt_dispatcher_bus_strobe_initiator.sv
// Issues single-cycle bus strobes, holds the transfer arguments until i_ready,
// and (with INTERRUPT_DISPATCHER_TIMEOUT_EN) aborts a transfer left unanswered.
module bus_strobe_initiator
    import interrupt_dispatcher_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_c,
    input  bus_req_t          req_c,
    interrupt_dispatcher_if.master bus,
    output logic              outstanding,
    output logic              done_c,
    output logic [DATA_W-1:0] rdata_c
`ifdef INTERRUPT_DISPATCHER_TIMEOUT_EN
    ,
    output logic              timeout_c
`endif
);

    logic     request_q, request_d;
    bus_req_t req_q, req_d;
    logic     outstanding_q, outstanding_d;
`ifdef INTERRUPT_DISPATCHER_TIMEOUT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

    // Strobe, argument capture and outstanding-transfer tracking.
    always_comb begin
        request_d     = start_c;
        req_d         = start_c ? req_c : req_q;
        done_c        = outstanding_q && bus.i_ready;
        outstanding_d = outstanding_q;
        if (start_c) begin
            outstanding_d = 1'b1;
        end else if (done_c) begin
            outstanding_d = 1'b0;
        end
`ifdef INTERRUPT_DISPATCHER_TIMEOUT_EN
        timeout_c = outstanding_q && !bus.i_ready && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
        cnt_d     = cnt_q;
        if (start_c) begin
            cnt_d = '0;
        end else if (outstanding_q) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        if (timeout_c) begin
            outstanding_d = 1'b0;
        end
`endif
    end

    // Bus-side registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            request_q     <= 1'b0;
            req_q         <= '0;
            outstanding_q <= 1'b0;
`ifdef INTERRUPT_DISPATCHER_TIMEOUT_EN
            cnt_q         <= '0;
`endif
        end else begin
            request_q     <= request_d;
            req_q         <= req_d;
            outstanding_q <= outstanding_d;
`ifdef INTERRUPT_DISPATCHER_TIMEOUT_EN
            cnt_q         <= cnt_d;
`endif
        end
    end

    assign bus.o_request = request_q;
    assign bus.o_rw      = req_q.rw;
    assign bus.o_address = req_q.addr;
    assign bus.o_wdata   = req_q.wdata;
    assign outstanding   = outstanding_q;
    assign rdata_c       = bus.i_rdata;

endmodule

// File: rtl/interrupt_dispatcher.sv
// Hart-side interrupt dispatcher: programs source enables after reset, claims on each
// interrupt pulse, hands the ID to the core and writes the completion once the handler ends.
// Optional bus timeout: define INTERRUPT_DISPATCHER_TIMEOUT_EN.
module interrupt_dispatcher
    import interrupt_dispatcher_pkg::*;
#(
    parameter logic [NUM_SOURCES-1:0] ENABLE_MASK = 4'b1111
)
(
    input  logic            i_clock,
    input  logic            i_reset,
    input  logic            i_interrupt,
    interrupt_dispatcher_if.master bus,
    output logic            o_irq_valid,
    output logic [ID_W-1:0] o_irq_id,
    input  logic            i_irq_ack,
    input  logic            i_irq_done,
    output logic            o_busy,
    output logic            o_error
);

    state_e            state_q, state_d;
    logic              pending_q, pending_d;
    logic [ID_W-1:0]   id_q, id_d;
    logic              irq_valid_q, irq_valid_d;
    logic [ID_W-1:0]   irq_id_q, irq_id_d;
    logic              busy_q, busy_d;
    logic              start_c;
    bus_req_t          req_c;
    logic              outstanding;
    logic              done_c;
    logic [DATA_W-1:0] rdata_c;
`ifdef INTERRUPT_DISPATCHER_TIMEOUT_EN
    logic              timeout_c;
    logic              error_q, error_d;
`endif

    bus_strobe_initiator u_bus (
        .clk         (i_clock),
        .rst_n       (i_reset),
        .start_c     (start_c),
        .req_c       (req_c),
        .bus         (bus),
        .outstanding (outstanding),
        .done_c      (done_c),
        .rdata_c     (rdata_c)
`ifdef INTERRUPT_DISPATCHER_TIMEOUT_EN
        ,
        .timeout_c   (timeout_c)
`endif
    );

    // Next-state, pending flag, claimed ID and bus requests.
    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        id_d      = id_q;
        start_c   = 1'b0;
        req_c     = '0;
`ifdef INTERRUPT_DISPATCHER_TIMEOUT_EN
        error_d   = error_q;
`endif
        case (state_q)
            ST_INIT: begin
                if (!outstanding) begin
                    start_c = 1'b1;
                    req_c   = '{rw: 1'b1, addr: PLIC_ENABLE_ADDR,
                                wdata: DATA_W'({ENABLE_MASK, 1'b0})};
                end
                if (done_c) state_d = ST_IDLE;
            end
            ST_IDLE: begin
                if (pending_q) begin
                    start_c   = 1'b1;
                    req_c     = '{rw: 1'b0, addr: PLIC_CLAIM_ADDR, wdata: '0};
                    pending_d = 1'b0;
                    state_d   = ST_CLAIM;
                end
            end
            ST_CLAIM: begin
                if (done_c) begin
                    if (claim_id_valid(rdata_c)) begin
                        id_d    = rdata_c[ID_W-1:0];
                        state_d = ST_DELIVER;
                    end else begin
                        id_d    = '0;
                        state_d = ST_COMPLETE;
                    end
                end
            end
            ST_DELIVER: begin
                if (i_irq_ack) state_d = i_irq_done ? ST_COMPLETE : ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                if (i_irq_done) state_d = ST_COMPLETE;
            end
            ST_COMPLETE: begin
                if (!outstanding) begin
                    start_c = 1'b1;
                    req_c   = '{rw: 1'b1, addr: PLIC_CLAIM_ADDR, wdata: DATA_W'(id_q)};
                end
                if (done_c) state_d = ST_IDLE;
            end
            default: state_d = ST_INIT;
        endcase
`ifdef INTERRUPT_DISPATCHER_TIMEOUT_EN
        // An unanswered claim is retried later, so its pending flag comes back.
        if (timeout_c) begin
            if (state_q == ST_CLAIM) pending_d = 1'b1;
            state_d = ST_IDLE;
            error_d = 1'b1;
        end
`endif
        if (i_interrupt) pending_d = 1'b1;

        irq_valid_d = (state_d == ST_DELIVER);
        irq_id_d    = (state_d == ST_DELIVER) ? id_d : '0;
        busy_d      = (state_d != ST_IDLE);
    end

    // State and registered core-side outputs.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state_q     <= ST_INIT;
            pending_q   <= 1'b0;
            id_q        <= '0;
            irq_valid_q <= 1'b0;
            irq_id_q    <= '0;
            busy_q      <= 1'b0;
`ifdef INTERRUPT_DISPATCHER_TIMEOUT_EN
            error_q     <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            id_q        <= id_d;
            irq_valid_q <= irq_valid_d;
            irq_id_q    <= irq_id_d;
            busy_q      <= busy_d;
`ifdef INTERRUPT_DISPATCHER_TIMEOUT_EN
            error_q     <= error_d;
`endif
        end
    end

    assign o_irq_valid = irq_valid_q;
    assign o_irq_id    = irq_id_q;
    assign o_busy      = busy_q;
`ifdef INTERRUPT_DISPATCHER_TIMEOUT_EN
    assign o_error     = error_q;
`else
    assign o_error     = 1'b0;
`endif

endmodule
